// File: rtl/timer_ctrl.sv
// Run-control sequencer for the two-digit BCD timer: key debounce, IDLE/RUN/PAUSE/DONE FSM, rate select.
// Optional build macro TIMER_CTRL_AUTORELOAD_EN: a terminal count reloads the preset and keeps running.
module timer_ctrl #(
  parameter int BASE_DIV   = 2_500_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_start,
  input  logic       key_load,
  input  logic       key_dir,
  input  logic       key_speed,
  input  logic [3:0] preset_ten,
  input  logic [3:0] preset_one,
  input  logic       cnt_zero,
  input  logic       cnt_max,
  output logic       tick,
  output logic       dir,
  output logic       load,
  output logic [3:0] load_ten,
  output logic [3:0] load_one,
  output logic [1:0] state,
  output logic [1:0] speed,
  output logic       done_led
);

  localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(BASE_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  logic [3:0]    keys_raw;
  logic [3:0]    sync1_q, sync2_q, lvl_q, evt_q;
  logic [DW-1:0] deb_cnt_q [4];
  logic          start_evt, load_evt, dir_evt, speed_evt;

  assign keys_raw  = {key_speed, key_dir, key_load, key_start};
  assign start_evt = evt_q[0];
  assign load_evt  = evt_q[1];
  assign dir_evt   = evt_q[2];
  assign speed_evt = evt_q[3];

  // A level is accepted only after DEB_CYCLES consecutive samples differ from the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      evt_q   <= '0;
      for (int k = 0; k < 4; k++) deb_cnt_q[k] <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      for (int k = 0; k < 4; k++) begin
        evt_q[k] <= 1'b0;
        if (sync2_q[k] == lvl_q[k]) begin
          deb_cnt_q[k] <= '0;
        end else if (deb_cnt_q[k] == DEB_LAST) begin
          deb_cnt_q[k] <= '0;
          lvl_q[k]     <= sync2_q[k];
          evt_q[k]     <= sync2_q[k];
        end else begin
          deb_cnt_q[k] <= deb_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  logic [PW-1:0] pre_q;
  logic          base;
  assign base = (pre_q == PRE_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= base ? '0 : pre_q + 1'b1;
  end

  state_e     state_q, state_d;
  logic       dir_q, dir_d;
  logic [1:0] speed_q, speed_d;
  logic [4:0] rate_q, rate_d, rate_last;
  logic       tick_q, tick_d, load_q, load_d;
  logic [3:0] lten_q, lone_q;
  logic       led_q, led_d;
  logic [3:0] dcnt_q, dcnt_d;
  logic       tick_due, terminal;

  always_comb begin
    unique case (speed_q)
      2'd0:    rate_last = 5'd19;
      2'd1:    rate_last = 5'd9;
      2'd2:    rate_last = 5'd4;
      default: rate_last = 5'd1;
    endcase
  end

  assign tick_due = (state_q == S_RUN) && base && (rate_q == rate_last);
  assign terminal = tick_due && (dir_q ? cnt_max : cnt_zero);

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    speed_d = speed_q;
    rate_d  = rate_q;
    tick_d  = 1'b0;
    load_d  = 1'b0;
    led_d   = led_q;
    dcnt_d  = dcnt_q;
    if (state_q == S_RUN && base) rate_d = tick_due ? 5'd0 : rate_q + 1'b1;
    unique case (state_q)
      S_IDLE: begin
        if (start_evt)     state_d = S_RUN;
        else if (load_evt) load_d  = 1'b1;
        if (dir_evt)       dir_d   = ~dir_q;
      end
      S_RUN: begin
        if (start_evt) begin
          state_d = S_PAUSE;
        end else if (terminal) begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
          load_d  = 1'b1;
`else
          state_d = S_DONE;
`endif
        end else if (tick_due) begin
          tick_d = 1'b1;
        end
      end
      S_PAUSE: begin
        if (start_evt) begin
          state_d = S_RUN;
        end else if (load_evt) begin
          load_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        if (start_evt) begin
          state_d = S_IDLE;
        end else if (load_evt) begin
          load_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
    if (state_d == S_RUN && state_q != S_RUN) rate_d = 5'd0;
    if (speed_evt) begin
      speed_d = speed_q + 1'b1;
      rate_d  = 5'd0;
    end
    // The blink counter only runs once DONE is already the current state, so the entry pulse is not counted.
    if (state_d != S_DONE || state_q != S_DONE) begin
      led_d  = 1'b0;
      dcnt_d = 4'd0;
    end else if (base) begin
      if (dcnt_q == 4'd9) begin
        led_d  = ~led_q;
        dcnt_d = 4'd0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      speed_q <= 2'd0;
      rate_q  <= 5'd0;
      tick_q  <= 1'b0;
      load_q  <= 1'b0;
      lten_q  <= 4'd0;
      lone_q  <= 4'd0;
      led_q   <= 1'b0;
      dcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      speed_q <= speed_d;
      rate_q  <= rate_d;
      tick_q  <= tick_d;
      load_q  <= load_d;
      lten_q  <= load_d ? clamp_bcd(preset_ten) : 4'd0;
      lone_q  <= load_d ? clamp_bcd(preset_one) : 4'd0;
      led_q   <= led_d;
      dcnt_q  <= dcnt_d;
    end
  end

  assign tick     = tick_q;
  assign dir      = dir_q;
  assign load     = load_q;
  assign load_ten = lten_q;
  assign load_one = lone_q;
  assign state    = state_q;
  assign speed    = speed_q;
  assign done_led = led_q;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with small BASE_DIV/DEB_CYCLES; state changes and load pulses go through scoreboard queues.
module tb_timer_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       k_start, k_load, k_dir, k_speed;
  logic [3:0] preset_ten, preset_one;
  logic       cnt_zero, cnt_max;
  logic       tick, dir, load, done_led;
  logic [3:0] load_ten, load_one;
  logic [1:0] state, speed;

  timer_ctrl #(.BASE_DIV(4), .DEB_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .key_start(k_start), .key_load(k_load), .key_dir(k_dir), .key_speed(k_speed),
    .preset_ten(preset_ten), .preset_one(preset_one),
    .cnt_zero(cnt_zero), .cnt_max(cnt_max),
    .tick(tick), .dir(dir), .load(load), .load_ten(load_ten), .load_one(load_one),
    .state(state), .speed(speed), .done_led(done_led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tick_cnt = 0, load_cnt = 0;
  int chg_cyc = 0, last_tick_cyc = 0, load_cyc = 0, led_cyc = 0;
  logic [1:0] prev_state = 2'd0;
  logic       prev_led = 1'b0;
  logic [31:0] exp_state_q[$];
  logic [31:0] exp_load_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Monitor samples 1 time unit after each rising edge; the stimulus block works 2 units after it.
  always @(posedge clk) begin
    logic [31:0] e;
    cyc++;
    #1;
    if (tick) begin
      tick_cnt++;
      last_tick_cyc = cyc;
    end
    if (state !== prev_state) begin
      prev_state = state;
      chg_cyc = cyc;
      e = (exp_state_q.size() > 0) ? exp_state_q.pop_front() : 32'hFFFF_FFFF;
      check("state_change", {30'd0, state}, e);
    end
    if (load) begin
      load_cnt++;
      load_cyc = cyc;
      e = (exp_load_q.size() > 0) ? exp_load_q.pop_front() : 32'hFFFF_FFFF;
      check("load_digits", {24'd0, load_ten, load_one}, e);
    end
    if (done_led !== prev_led) begin
      prev_led = done_led;
      led_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0:       k_start = v;
      1:       k_load  = v;
      2:       k_dir   = v;
      default: k_speed = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b1);
    repeat (5) step();
    set_key(k, 1'b0);
    repeat (6) step();
  endtask

  task automatic wait_tick(output int at, input int limit);
    int n0 = tick_cnt;
    int i = 0;
    while (tick_cnt == n0 && i < limit) begin
      step();
      i++;
    end
    check("tick_seen", {31'd0, tick_cnt != n0}, 32'd1);
    at = last_tick_cyc;
  endtask

  task automatic wait_state(input string tag, input logic [1:0] s, input int limit);
    int i = 0;
    while (state !== s && i < limit) begin
      step();
      i++;
    end
    check(tag, {30'd0, state}, {30'd0, s});
  endtask

  task automatic wait_led(input logic v, input int limit);
    int i = 0;
    while (done_led !== v && i < limit) begin
      step();
      i++;
    end
    check("led_level", {31'd0, done_led}, {31'd0, v});
  endtask

  function automatic logic [31:0] outs();
    return {14'd0, state, speed, dir, tick, load, load_ten, load_one, done_led};
  endfunction

  int t1, t2, tc, lc, d;

  initial begin
    rst_n = 1'b0;
    k_start = 0; k_load = 0; k_dir = 0; k_speed = 0;
    preset_ten = 4'd0; preset_one = 4'd0;
    cnt_zero = 1'b0; cnt_max = 1'b0;
    repeat (3) step();
    check("reset_outputs", outs(), 32'd0);
    rst_n = 1'b1;
    step();

    k_start = 1'b1;
    step(); step();
    k_start = 1'b0;
    repeat (10) step();
    check("glitch_state", {30'd0, state}, 32'd0);

    preset_ten = 4'hC; preset_one = 4'd3;
    exp_load_q.push_back(32'h93);
    press(1);
    check("idle_load_state", {30'd0, state}, 32'd0);
    check("idle_load_count", load_cnt, 1);

    press(2);
    check("dir_toggle_up", {31'd0, dir}, 32'd1);
    press(2);
    check("dir_toggle_down", {31'd0, dir}, 32'd0);

    exp_state_q.push_back(32'd1);
    press(0);
    wait_tick(t1, 200);
    d = t1 - chg_cyc;
    check("first_tick_window", {31'd0, (d >= 77 && d <= 80)}, 32'd1);
    wait_tick(t2, 200);
    check("tick_period_1hz", t2 - t1, 80);

    press(3); press(3); press(3);
    check("speed_three", {30'd0, speed}, 32'd3);
    wait_tick(t1, 100);
    wait_tick(t2, 100);
    check("tick_period_10hz", t2 - t1, 8);
    press(3);
    check("speed_wrap", {30'd0, speed}, 32'd0);

    exp_state_q.push_back(32'd2);
    press(0);
    tc = tick_cnt;
    repeat (150) step();
    check("pause_no_tick", tick_cnt - tc, 0);
    exp_state_q.push_back(32'd1);
    press(0);
    wait_tick(t1, 200);
    d = t1 - chg_cyc;
    check("resume_tick_window", {31'd0, (d >= 77 && d <= 80)}, 32'd1);

    cnt_zero = 1'b1;
    tc = tick_cnt;
`ifdef TIMER_CTRL_AUTORELOAD_EN
    exp_load_q.push_back(32'h93);
    lc = load_cnt;
    for (int i = 0; i < 200 && load_cnt == lc; i++) step();
    check("autoreload_load", load_cnt - lc, 1);
    check("autoreload_state", {30'd0, state}, 32'd1);
    check("autoreload_no_tick", tick_cnt - tc, 0);
    cnt_zero = 1'b0;
    wait_tick(t1, 200);
    check("autoreload_next_tick", t1 - load_cyc, 80);
    exp_state_q.push_back(32'd2);
    press(0);
    exp_load_q.push_back(32'h93);
    exp_state_q.push_back(32'd0);
    press(1);
`else
    exp_state_q.push_back(32'd3);
    wait_state("done_entry", 2'd3, 200);
    check("done_no_tick", tick_cnt - tc, 0);
    cnt_zero = 1'b0;
    wait_led(1'b1, 100);
    check("led_first_toggle", led_cyc - chg_cyc, 40);
    t1 = led_cyc;
    wait_led(1'b0, 100);
    check("led_period", led_cyc - t1, 40);
    wait_led(1'b1, 100);
    exp_state_q.push_back(32'd0);
    press(0);
    check("done_exit_led", {31'd0, done_led}, 32'd0);
`endif

    exp_state_q.push_back(32'd1);
    press(0);
    exp_state_q.push_back(32'd2);
    press(0);
    preset_ten = 4'd5; preset_one = 4'hF;
    exp_load_q.push_back(32'h59);
    exp_state_q.push_back(32'd0);
    press(1);
    check("pause_load_idle", {30'd0, state}, 32'd0);

    press(2);
    check("dir_before_run", {31'd0, dir}, 32'd1);
    press(3);
    check("speed_before_run", {30'd0, speed}, 32'd1);
    exp_state_q.push_back(32'd1);
    press(0);
    repeat (20) step();
    exp_state_q.push_back(32'd0);
    rst_n = 1'b0;
    #1;
    check("reset_mid_run", outs(), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    tc = tick_cnt;
    lc = load_cnt;
    repeat (60) step();
    check("no_trailing_tick", tick_cnt - tc, 0);
    check("no_trailing_load", load_cnt - lc, 0);

    check("state_queue_empty", exp_state_q.size(), 0);
    check("load_queue_empty", exp_load_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
